bop_range_store: RTL



---
 rtl/bop_pkg.sv | 18 +
 rtl/bop_range_match.sv | 32 +++
 rtl/bop_range_store.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bop_pkg.sv
// Shared types for the overflow-interval store: one stored interval and a
// helper that tests an address against it.
package bop_pkg;

  localparam int BOP_ADDR_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [BOP_ADDR_W-1:0] first;
    logic [BOP_ADDR_W-1:0] last;
  } bop_range_t;

  // True when addr lies inside a valid closed interval (unsigned compare).
  function automatic logic range_hit(input bop_range_t r, input logic [BOP_ADDR_W-1:0] addr);
    return r.valid && (r.first <= addr) && (addr <= r.last);
  endfunction

endpackage

// File: rtl/bop_range_match.sv
// Per-entry comparator: query hit, first-byte hit, and whether the incoming
// write overlaps or touches this entry (merge candidate).
module bop_range_match
  import bop_pkg::*;
(
  input  bop_range_t             entry,
  input  logic [BOP_ADDR_W-1:0]  find_addr,
  input  logic [BOP_ADDR_W-1:0]  wr_first,
  input  logic [BOP_ADDR_W-1:0]  wr_last,
  output logic                   hit,
  output logic                   is_first,
  output logic                   merge_cand
);

  localparam int EXT_W = BOP_ADDR_W + 1;

  // One extra bit so that last+1 of an all-ones bound does not wrap to zero.
  logic [EXT_W-1:0] wr_first_ext;
  logic [EXT_W-1:0] wr_last_inc;
  logic [EXT_W-1:0] ent_first_ext;
  logic [EXT_W-1:0] ent_last_inc;

  assign wr_first_ext  = {1'b0, wr_first};
  assign wr_last_inc   = {1'b0, wr_last} + EXT_W'(1);
  assign ent_first_ext = {1'b0, entry.first};
  assign ent_last_inc  = {1'b0, entry.last} + EXT_W'(1);

  assign hit        = range_hit(entry, find_addr);
  assign is_first   = entry.valid && (find_addr == entry.first);
  assign merge_cand = entry.valid && (wr_first_ext <= ent_last_inc) && (wr_last_inc >= ent_first_ext);

endmodule

// File: rtl/bop_range_store.sv
// Circular store of closed byte-address intervals with combinational lookup.
// Writes allocate oldest-first; a full store overwrites its oldest entry.
// Optional build macro BOP_RANGE_MERGE_EN: a legal write that overlaps or is
// adjacent to a valid entry widens the lowest-index such entry in place.
module bop_range_store
  import bop_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_write_i,
  input  logic [ADDR_W-1:0]        addr_first_i,
  input  logic [ADDR_W-1:0]        addr_last_i,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        find_addr_i,
  output logic                     addr_in_range_o,
  output logic                     addr_is_first_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     overwrite_o,
  output logic                     bad_write_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pointer wrap relies on DEPTH being a power of two; entries share the
  // package interval type, so the address widths must agree.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bop_range_store: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W != BOP_ADDR_W) begin : g_bad_addr_w
      $error("bop_range_store: ADDR_W must equal BOP_ADDR_W");
    end
  endgenerate

  bop_range_t        entry_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg,    wr_ptr_next;
  logic [CNT_W-1:0]  count_reg,     count_next;
  logic              overwrite_reg, overwrite_next;
  logic              bad_write_reg, bad_write_next;

  logic [DEPTH-1:0]  hit_vec;
  logic [DEPTH-1:0]  first_vec;
  logic [DEPTH-1:0]  merge_vec;
  logic [DEPTH-1:0]  entry_we;
  bop_range_t        entry_wdata;
  logic              clear_all;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      bop_range_match u_match (
        .entry      (entry_reg[gi]),
        .find_addr  (find_addr_i),
        .wr_first   (addr_first_i),
        .wr_last    (addr_last_i),
        .hit        (hit_vec[gi]),
        .is_first   (first_vec[gi]),
        .merge_cand (merge_vec[gi])
      );

      // Entry storage: reset/flush only drop the valid bit, bounds are don't-care.
      always_ff @(posedge clk_i) begin
        if (rst_i || clear_all) begin
          entry_reg[gi].valid <= 1'b0;
        end else if (entry_we[gi]) begin
          entry_reg[gi] <= entry_wdata;
        end
      end
    end
  endgenerate

`ifdef BOP_RANGE_MERGE_EN
  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx;

  // Lowest-index merge candidate wins: scan downward so the last match kept is the lowest.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (merge_vec[i]) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end
`else
  logic unused_merge;
  assign unused_merge = ^merge_vec;
`endif

  // Write/flush decode: flush dominates, malformed intervals are rejected.
  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    count_next        = count_reg;
    overwrite_next    = 1'b0;
    bad_write_next    = 1'b0;
    entry_we          = '0;
    entry_wdata.valid = 1'b1;
    entry_wdata.first = addr_first_i;
    entry_wdata.last  = addr_last_i;
    clear_all         = 1'b0;

    if (flush_i) begin
      clear_all   = 1'b1;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (en_write_i) begin
      if (addr_first_i > addr_last_i) begin
        bad_write_next = 1'b1;
`ifdef BOP_RANGE_MERGE_EN
      end else if (merge_hit) begin
        entry_we[merge_idx] = 1'b1;
        entry_wdata.first   = (addr_first_i < entry_reg[merge_idx].first) ? addr_first_i
                                                                          : entry_reg[merge_idx].first;
        entry_wdata.last    = (addr_last_i > entry_reg[merge_idx].last) ? addr_last_i
                                                                        : entry_reg[merge_idx].last;
`endif
      end else begin
        entry_we[wr_ptr_reg] = 1'b1;
        wr_ptr_next          = wr_ptr_reg + PTR_W'(1);
        if (count_reg == FULL_CNT) begin
          overwrite_next = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
    end
  end

  // Pointer, occupancy and one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overwrite_reg <= 1'b0;
      bad_write_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      overwrite_reg <= overwrite_next;
      bad_write_reg <= bad_write_next;
    end
  end

  assign addr_in_range_o = |hit_vec;
  assign addr_is_first_o = |first_vec;
  assign count_o         = count_reg;
  assign full_o          = (count_reg == FULL_CNT);
  assign overwrite_o     = overwrite_reg;
  assign bad_write_o     = bad_write_reg;

endmodule
